// File: rtl/xgriscv_muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM state encoding and the default datapath width.
package xgriscv_muldiv_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_PREP = 2'd1,
        MD_CALC = 2'd2,
        MD_FIN  = 2'd3
    } md_state_e;

endpackage

// File: rtl/xgriscv_muldiv_negate.sv
// Conditional two's-complement negation, used for operand magnitudes
// and for sign correction of the final result.
module xgriscv_muldiv_negate #(
    parameter int W = 32
) (
    input  logic         en_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    assign dout_o = en_i ? (~din_i + W'(1)) : din_i;

endmodule

// File: rtl/xgriscv_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide sharing one 2*XLEN accumulator; one op at a time, registered result.
module xgriscv_muldiv
    import xgriscv_muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    md_state_e          state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [XLEN-1:0]    a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]    opnd_q, opnd_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               busy_q, done_q;

    logic               is_div, is_rem, sgn_a, sgn_b;
    logic               div_zero, div_ovf;
    logic [XLEN-1:0]    mag_a, mag_b, spec_res, fin_res;
    logic [XLEN:0]      mul_sum, div_rem_sh, div_diff;
    logic [2*XLEN-1:0]  step, res_raw, res_fix;

    assign is_div = op_q[2];
    assign is_rem = op_q[2] & op_q[1];
    assign sgn_a  = a_q[XLEN-1] & (op_q == MD_MULH || op_q == MD_MULHSU ||
                                   op_q == MD_DIV  || op_q == MD_REM);
    assign sgn_b  = b_q[XLEN-1] & (op_q == MD_MULH || op_q == MD_DIV || op_q == MD_REM);

    assign div_zero = is_div && (b_q == '0);
    assign div_ovf  = (op_q == MD_DIV || op_q == MD_REM) &&
                      (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

    always_comb begin
        spec_res = '0;
        if (div_zero)
            spec_res = is_rem ? a_q : '1;
        else if (div_ovf)
            spec_res = is_rem ? '0 : a_q;
    end

    xgriscv_muldiv_negate #(.W(XLEN)) u_neg_a (
        .en_i(sgn_a), .din_i(a_q), .dout_o(mag_a)
    );
    xgriscv_muldiv_negate #(.W(XLEN)) u_neg_b (
        .en_i(sgn_b), .din_i(b_q), .dout_o(mag_b)
    );

    // Multiply: multiplier sits in the low half and shifts out LSB-first.
    // Divide: remainder:quotient shifts left, quotient bits enter at the LSB.
    assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff   = div_rem_sh - {1'b0, opnd_q};

    always_comb begin
        if (!is_div)
            step = {mul_sum, acc_q[XLEN-1:1]};
        else if (div_diff[XLEN])
            step = {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    // Division results are zero-extended so one wide negator serves both paths.
    assign res_raw = is_div ? {{XLEN{1'b0}}, (op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0])}
                            : step;

    xgriscv_muldiv_negate #(.W(2*XLEN)) u_neg_res (
        .en_i(neg_q), .din_i(res_raw), .dout_o(res_fix)
    );

    assign fin_res = (is_div || op_q == MD_MUL) ? res_fix[XLEN-1:0] : res_fix[2*XLEN-1:XLEN];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = MD_PREP;
                end
            end
            MD_PREP: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else if (div_zero || div_ovf) begin
                    result_d = spec_res;
                    state_d  = MD_FIN;
                end else begin
                    acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    opnd_d  = is_div ? mag_b : mag_a;
                    cnt_d   = '0;
                    neg_d   = is_rem ? sgn_a : (sgn_a ^ sgn_b);
                    state_d = MD_CALC;
                end
            end
            MD_CALC: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d = step;
                    if (cnt_q == CW'(XLEN-1)) begin
                        result_d = fin_res;
                        state_d  = MD_FIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            MD_FIN:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= MD_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            busy_q   <= (state_d != MD_IDLE);
            done_q   <= (state_d == MD_FIN);
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_xgriscv_muldiv.sv
// Scoreboard bench for xgriscv_muldiv: directed RV32M corner cases plus
// random ops checked against a plain-arithmetic reference model.
module tb_xgriscv_muldiv;
    import xgriscv_muldiv_pkg::*;

    localparam int XL = 32;

    logic          clk = 1'b0, rstn = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]    op = '0;
    logic [XL-1:0] a = '0, b = '0;
    logic          busy, done;
    logic [XL-1:0] result;

    xgriscv_muldiv #(.XLEN(XL)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
        logic [2:0]  op;
    } exp_t;

    exp_t        sbq[$];
    int          nvec = 0, nfail = 0, cyc = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0]        xs, ys, xu, yu, p;
        logic signed [31:0] sx, sy;
        xs = {{32{x[31]}}, x}; ys = {{32{y[31]}}, y};
        xu = {32'b0, x};       yu = {32'b0, y};
        sx = x;                sy = y;
        case (o)
            MD_MUL:    begin p = xs * ys; return p[31:0];  end
            MD_MULH:   begin p = xs * ys; return p[63:32]; end
            MD_MULHSU: begin p = xs * yu; return p[63:32]; end
            MD_MULHU:  begin p = xu * yu; return p[63:32]; end
            MD_DIV: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
                return sx / sy;
            end
            MD_DIVU: return (y == 0) ? 32'hFFFFFFFF : x / y;
            MD_REM: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                return sx % sy;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 0) return 2;
        if ((o == MD_DIV || o == MD_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 2;
        return XL + 2;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                last_res = '0;
            end else if (done) begin
                if (sbq.size() == 0) begin
                    nvec++; nfail++;
                    $display("FAIL spurious_done: got result %h expected no done", result);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("result_op%0d", e.op), result, e.res);
                    chk($sformatf("latency_op%0d", e.op), 32'(cyc - e.t0), 32'(e.lat));
                    last_res = e.res;
                end
            end
        end
    end

    // Holds start until the unit is idle, so a request raised during the done
    // cycle is taken on the first edge after FIN.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_r, input bit track);
        int n = 0;
        start = 1'b1; op = o; a = x; b = y;
        while (busy && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            nvec++; nfail++;
            $display("FAIL issue_timeout: busy stuck high, expected idle within 100 cycles");
        end
        if (track) sbq.push_back('{exp_r, lat_of(o, x, y), cyc, o});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            nvec++; nfail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        logic [2:0]  o;
        logic [31:0] x, y;

        #1 rstn = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_result", result, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // MUL with busy-length check; start held high mid-op must not restart it.
        issue(MD_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            start = (nb < 8); op = MD_DIVU; a = 32'd0; b = 32'd0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("mul_busy_cycles", 32'(nb), 32'd34);

        issue(MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b1);
        issue(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
        issue(MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b1);
        issue(MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b1);
        issue(MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b1);
        issue(MD_DIVU,   32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 1'b1);
        issue(MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
        issue(MD_REMU,   32'd5,        32'd0,        32'd5,        1'b1);
        issue(MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1);
        issue(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        issue(MD_DIV,    32'd100,      32'd0,        32'hFFFFFFFF, 1'b1);
        drain();

        // Flush at T+10 of a DIV: no done, busy drops, result held.
        issue(MD_DIV, 32'd1000, 32'd7, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 0);
        chk("flush_result_held", result, last_res);
        repeat (40) @(negedge clk);
        chk("flush_result_after", result, last_res);
        issue(MD_MUL, 32'd12345, 32'd678, 32'd8369910, 1'b1);
        drain();

        // Flush together with start in IDLE: request refused.
        start = 1'b1; flush = 1'b1; op = MD_MUL; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_with_start_busy", 32'(busy), 0);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-CALC.
        issue(MD_MUL, 32'd9, 32'd9, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_done", 32'(done), 0);
        chk("async_rst_result", result, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            x = rnd_opnd();
            y = rnd_opnd();
            issue(o, x, y, ref_md(o, x, y), 1'b1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
